// File: rtl/video_stream_pkg.sv
// Pixel format, colour constants and frame-control state type shared by the
// video source and the receive-side detector.
package video_stream_pkg;
    localparam int PIXEL_W = 30;
    typedef logic [PIXEL_W-1:0] pixel_t;

    localparam int R_MSB = 29;
    localparam int R_LSB = 20;
    localparam int G_MSB = 19;
    localparam int G_LSB = 10;
    localparam int B_MSB = 9;
    localparam int B_LSB = 0;

    localparam pixel_t COLOUR_RED   = 30'h3FF00000;
    localparam pixel_t COLOUR_BLACK = 30'h0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_GAP
    } frame_state_e;
endpackage

// File: rtl/pixel_position_counter.sv
// Raster-order x/y position counter. It steps one pixel per advance strobe and
// wraps from the last pixel back to (0,0), with first/last flags for the current position.
module pixel_position_counter #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      advance,
    output logic [$clog2(WIDTH)-1:0]  x,
    output logic [$clog2(HEIGHT)-1:0] y,
    output logic                      first,
    output logic                      last
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic [XW-1:0] x_d, x_q;
    logic [YW-1:0] y_d, y_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (advance) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign first = (x_q == '0) && (y_q == '0);
    assign last  = (x_q == X_LAST) && (y_q == Y_LAST);
endmodule

// File: rtl/target_frame_source.sv
// Avalon-ST test-pattern source: solid-background frames carrying a BOX x BOX target
// patch at a position and colour latched at each frame start.
module target_frame_source
    import video_stream_pkg::*;
#(
    parameter int WIDTH     = 320,
    parameter int HEIGHT    = 240,
    parameter int BOX       = 16,
    parameter int FRAME_GAP = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [$clog2(WIDTH)-1:0]  target_x,
    input  logic [$clog2(HEIGHT)-1:0] target_y,
    input  logic [PIXEL_W-1:0]        target_colour,
    input  logic [PIXEL_W-1:0]        bg_colour,
    output logic [PIXEL_W-1:0]        data_out,
    output logic                      startofpacket_out,
    output logic                      endofpacket_out,
    output logic                      valid_out,
    input  logic                      ready_in,
    output logic                      frame_done,
    output logic [15:0]               frame_count
);
    localparam int XW    = $clog2(WIDTH);
    localparam int YW    = $clog2(HEIGHT);
    localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

    frame_state_e     state_d, state_q;
    logic [GAP_W-1:0] gap_d, gap_q;
    logic [XW-1:0]    tx_d, tx_q;
    logic [YW-1:0]    ty_d, ty_q;
    pixel_t           tcol_d, tcol_q, bcol_d, bcol_q;
    pixel_t           data_d, data_q;
    logic             sop_d, sop_q, eop_d, eop_q, valid_d, valid_q, done_d, done_q;
    logic [15:0]      count_d, count_q;

    logic [XW-1:0]    pos_x;
    logic [YW-1:0]    pos_y;
    logic             pos_first, pos_last;
    logic             start, advance, accept;

    // The counter runs one beat ahead of the output registers: it holds the
    // position of the beat that will be loaded on the next advance.
    pixel_position_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_pos (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .x       (pos_x),
        .y       (pos_y),
        .first   (pos_first),
        .last    (pos_last)
    );

    // One extra bit on every operand so the box clips at the right/bottom edge.
    function automatic pixel_t select_pixel(
        input logic [XW-1:0] px, input logic [YW-1:0] py,
        input logic [XW-1:0] tx, input logic [YW-1:0] ty,
        input pixel_t tc, input pixel_t bc
    );
        logic [XW:0] xe, txe;
        logic [YW:0] ye, tye;
        logic        in_x, in_y;
        xe   = {1'b0, px};
        txe  = {1'b0, tx};
        ye   = {1'b0, py};
        tye  = {1'b0, ty};
        in_x = (xe >= txe) && (xe < txe + (XW+1)'(BOX));
        in_y = (ye >= tye) && (ye < tye + (YW+1)'(BOX));
        return (in_x && in_y) ? tc : bc;
    endfunction

    assign accept = valid_q && ready_in;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        tcol_d  = tcol_q;
        bcol_d  = bcol_q;
        data_d  = data_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        count_d = count_q;
        start   = 1'b0;
        advance = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) start = 1'b1;
            end
            ST_STREAM: begin
                if (accept) begin
                    if (eop_q) begin
                        done_d  = 1'b1;
                        count_d = count_q + 16'd1;
                        if (FRAME_GAP == 0) begin
                            if (enable) start = 1'b1;
                            else        state_d = ST_IDLE;
                        end else begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (enable) start = 1'b1;
                    else        state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            state_d = ST_STREAM;
            tx_d    = target_x;
            ty_d    = target_y;
            tcol_d  = target_colour;
            bcol_d  = bg_colour;
            advance = 1'b1;
        end

        if (advance) begin
            data_d  = select_pixel(pos_x, pos_y, tx_d, ty_d, tcol_d, bcol_d);
            sop_d   = pos_first;
            eop_d   = pos_last;
            valid_d = 1'b1;
        end else if (state_d != ST_STREAM) begin
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            tcol_q  <= '0;
            bcol_q  <= '0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            tcol_q  <= tcol_d;
            bcol_q  <= bcol_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign data_out          = data_q;
    assign startofpacket_out = sop_q;
    assign endofpacket_out   = eop_q;
    assign valid_out         = valid_q;
    assign frame_done        = done_q;
    assign frame_count       = count_q;
endmodule

// File: tb/tb_target_frame_source.sv
// Bench for target_frame_source on an 8x4 raster with a 2x2 target, one instance
// with a 4-cycle inter-frame gap and one with no gap.
module tb_target_frame_source;
    import video_stream_pkg::*;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int BOX  = 2;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        reset;
    logic        en   [2];
    logic        rdy  [2];
    logic [2:0]  tx;
    logic [1:0]  ty;
    pixel_t      tcol, bcol;
    pixel_t      dout [2];
    logic        sop  [2];
    logic        eop  [2];
    logic        vld  [2];
    logic        done [2];
    logic [15:0] fcnt [2];

    int n_cmp  = 0;
    int n_fail = 0;
    int fc [2] = '{0, 0};

    always #5 clk = ~clk;

    target_frame_source #(.WIDTH(W), .HEIGHT(H), .BOX(BOX), .FRAME_GAP(4)) dut_gap (
        .clk(clk), .reset(reset), .enable(en[0]),
        .target_x(tx), .target_y(ty), .target_colour(tcol), .bg_colour(bcol),
        .data_out(dout[0]), .startofpacket_out(sop[0]), .endofpacket_out(eop[0]),
        .valid_out(vld[0]), .ready_in(rdy[0]),
        .frame_done(done[0]), .frame_count(fcnt[0])
    );

    target_frame_source #(.WIDTH(W), .HEIGHT(H), .BOX(BOX), .FRAME_GAP(0)) dut_nogap (
        .clk(clk), .reset(reset), .enable(en[1]),
        .target_x(tx), .target_y(ty), .target_colour(tcol), .bg_colour(bcol),
        .data_out(dout[1]), .startofpacket_out(sop[1]), .endofpacket_out(eop[1]),
        .valid_out(vld[1]), .ready_in(rdy[1]),
        .frame_done(done[1]), .frame_count(fcnt[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Raster index k maps to (k % W, k / W); the patch covers [tx, tx+BOX) x [ty, ty+BOX).
    function automatic pixel_t model_pixel(input int k, input int ftx, input int fty,
                                           input pixel_t tc, input pixel_t bc);
        int x = k % W;
        int y = k / W;
        return (x >= ftx && x < ftx + BOX && y >= fty && y < fty + BOX) ? tc : bc;
    endfunction

    function automatic pixel_t rand_pixel();
        return 30'($urandom);
    endfunction

    task automatic run_frame(input int inst, input int rdy_pct, input int ftx, input int fty,
                             input pixel_t tc, input pixel_t bc, input int exp_wait,
                             input int drop_after, input int chg_after, input int chg_tx,
                             input int stop_at);
        int     waited  = 0;
        int     k       = 0;
        int     cyc     = 0;
        bit     stalled = 1'b0;
        bit     first;
        bit     r;
        pixel_t pd = '0;
        logic   ps = 1'b0;
        logic   pe = 1'b0;

        while (vld[inst] !== 1'b1 && waited < 40) begin
            if (waited > 0) chk("done_idle", 32'(done[inst]), 32'd0);
            @(posedge clk); #1;
            waited++;
        end
        chk("sop_wait", waited, exp_wait);
        if (vld[inst] !== 1'b1) return;
        first = (waited == 0);

        while (k < NPIX && cyc < 400) begin
            if (k == stop_at) return;
            if (!first) chk("done_mid", 32'(done[inst]), 32'd0);
            first = 1'b0;
            chk("valid_hold", 32'(vld[inst]), 32'd1);
            if (stalled) begin
                chk("stall_data", 32'(dout[inst]), 32'(pd));
                chk("stall_sop", 32'(sop[inst]), 32'(ps));
                chk("stall_eop", 32'(eop[inst]), 32'(pe));
            end
            r = (int'($urandom_range(0, 99)) < rdy_pct);
            rdy[inst] = r;
            if (r) begin
                chk("beat_data", 32'(dout[inst]), 32'(model_pixel(k, ftx, fty, tc, bc)));
                chk("beat_sop", 32'(sop[inst]), 32'(k == 0));
                chk("beat_eop", 32'(eop[inst]), 32'(k == NPIX - 1));
                k++;
                if (k == drop_after) en[inst] = 1'b0;
                if (k == chg_after) tx = 3'(chg_tx);
            end
            stalled = !r;
            pd = dout[inst];
            ps = sop[inst];
            pe = eop[inst];
            @(posedge clk); #1;
            cyc++;
        end
        chk("frame_beats", k, NPIX);
        chk("frame_done", 32'(done[inst]), 32'd1);
        fc[inst]++;
        chk("frame_count", 32'(fcnt[inst]), fc[inst]);
    endtask

    initial begin
        reset  = 1'b0;
        en[0]  = 1'b0;
        en[1]  = 1'b0;
        rdy[0] = 1'b0;
        rdy[1] = 1'b0;
        tx     = 3'd3;
        ty     = 2'd1;
        tcol   = COLOUR_RED;
        bcol   = COLOUR_BLACK;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_data", 32'(dout[i]), 32'd0);
            chk("rst_sop", 32'(sop[i]), 32'd0);
            chk("rst_eop", 32'(eop[i]), 32'd0);
            chk("rst_valid", 32'(vld[i]), 32'd0);
            chk("rst_done", 32'(done[i]), 32'd0);
            chk("rst_count", 32'(fcnt[i]), 32'd0);
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_valid", 32'(vld[0]), 32'd0);

        // Target (3,1), full-rate ready, starting from idle.
        en[0] = 1'b1;
        run_frame(0, 100, 3, 1, tcol, bcol, 1, -1, -1, 0, -1);

        // Same frame under random backpressure, after the 4-cycle gap.
        run_frame(0, 50, 3, 1, tcol, bcol, 4, -1, -1, 0, -1);

        // Corner target: clips at the right/bottom edge, no wrap to column/row 0.
        tx   = 3'd7;
        ty   = 2'd3;
        tcol = rand_pixel();
        bcol = tcol ^ 30'h2AAAAAAA;
        run_frame(0, 100, 7, 3, tcol, bcol, 4, -1, -1, 0, -1);

        // Enable dropped after beat 10: frame completes, then gap and idle.
        tx   = 3'd3;
        ty   = 2'd1;
        tcol = rand_pixel();
        bcol = tcol ^ 30'h15555555;
        run_frame(0, 60, 3, 1, tcol, bcol, 4, 11, -1, 0, -1);
        repeat (12) begin
            @(posedge clk); #1;
            chk("gap_valid", 32'(vld[0]), 32'd0);
            chk("gap_done", 32'(done[0]), 32'd0);
        end
        chk("idle_count", 32'(fcnt[0]), fc[0]);

        // No-gap instance: target_x changes mid-frame, next frame picks it up back-to-back.
        tcol  = rand_pixel();
        bcol  = tcol ^ 30'h3C3C3C3C;
        en[1] = 1'b1;
        run_frame(1, 100, 3, 1, tcol, bcol, 1, -1, 6, 5, -1);
        run_frame(1, 50, 5, 1, tcol, bcol, 0, 2, -1, 0, -1);
        @(posedge clk); #1;
        chk("nogap_idle", 32'(vld[1]), 32'd0);

        // Reset in the middle of a frame, then restart from pixel (0,0).
        tx    = 3'd3;
        en[0] = 1'b1;
        run_frame(0, 100, 3, 1, tcol, bcol, 1, -1, -1, 0, 17);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rstmid_valid", 32'(vld[i]), 32'd0);
            chk("rstmid_sop", 32'(sop[i]), 32'd0);
            chk("rstmid_eop", 32'(eop[i]), 32'd0);
            chk("rstmid_count", 32'(fcnt[i]), 32'd0);
        end
        fc[0] = 0;
        fc[1] = 0;
        @(posedge clk); #1;
        chk("rst_hold_valid", 32'(vld[0]), 32'd0);
        reset = 1'b1;
        run_frame(0, 100, 3, 1, tcol, bcol, 1, -1, -1, 0, -1);
        en[0] = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
